// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered multi-domain reset release after PLL lock
//
// Purpose: synchronises an asynchronous PLL lock, waits a hold-off period,
// then releases N_OUT active-high resets one by one (bit 0 first) with a
// fixed spacing. Any lock loss or soft reset request re-asserts every domain.
//
// Ports:
//   clk            single clock; drive from the slowest domain being reset
//   rst_n          asynchronous active-low reset
//   locked         PLL/MMCM lock, asynchronous to clk
//   soft_rst       synchronous level-sensitive software reset request
//   rst_out        per-domain reset, active-high, registered
//   all_released   high while every rst_out bit is 0
//   lock_lost_cnt  saturating count of lock-loss events
module reset_sequencer #(
    parameter int N_OUT       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             soft_rst,
    output logic [N_OUT-1:0] rst_out,
    output logic             all_released,
    output logic [7:0]       lock_lost_cnt
);

    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [N_OUT-1:0]       rst_out_nxt;
    logic                   all_released_nxt;
    logic [7:0]             lock_lost_cnt_nxt;
    logic                   lock_loss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_ASSERT;
            rst_out       <= '1;
            all_released  <= 1'b0;
            lock_lost_cnt <= 8'd0;
            cnt           <= '0;
            idx           <= '0;
        end else begin
            state         <= state_nxt;
            rst_out       <= rst_out_nxt;
            all_released  <= all_released_nxt;
            lock_lost_cnt <= lock_lost_cnt_nxt;
            cnt           <= cnt_nxt;
            idx           <= idx_nxt;
        end
    end

    // Lock is only "lost" once we have started to act on it; sitting in
    // ASSERT with no lock is the normal waiting condition and is not counted.
    assign lock_loss = !locked_s && (state != ST_ASSERT);

    always_comb begin
        state_nxt         = state;
        rst_out_nxt       = rst_out;
        all_released_nxt  = all_released;
        lock_lost_cnt_nxt = lock_lost_cnt;
        cnt_nxt           = cnt;
        idx_nxt           = idx;

        if (lock_loss || soft_rst) begin
            state_nxt        = ST_ASSERT;
            rst_out_nxt      = '1;
            all_released_nxt = 1'b0;
            cnt_nxt          = '0;
            idx_nxt          = '0;
            if (lock_loss && (lock_lost_cnt != 8'hFF)) begin
                lock_lost_cnt_nxt = lock_lost_cnt + 8'd1;
            end
        end else begin
            case (state)
                ST_ASSERT: begin
                    rst_out_nxt      = '1;
                    all_released_nxt = 1'b0;
                    cnt_nxt          = '0;
                    idx_nxt          = '0;
                    if (locked_s) begin
                        state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        // Shifting a zero in from the bottom keeps rst_out
                        // thermometer-shaped by construction.
                        rst_out_nxt = rst_out << 1;
                        cnt_nxt     = '0;
                        idx_nxt     = '0;
                        if (N_OUT == 1) begin
                            state_nxt        = ST_RUN;
                            all_released_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_RELEASE;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt == STEP_LAST) begin
                        rst_out_nxt = rst_out << 1;
                        cnt_nxt     = '0;
                        idx_nxt     = idx + IDX_W'(1);
                        if (int'(idx) + 1 == N_OUT - 1) begin
                            state_nxt        = ST_RUN;
                            all_released_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    all_released_nxt = 1'b1;
                end
                default: begin
                    state_nxt = ST_ASSERT;
                end
            endcase
        end
    end

endmodule
